nibble_serial_add_ctrl: RTL and testbench

- Sequencer that performs a WIDTH = 4*NIBBLES bit add/subtract by time-multiplexing one external 4-bit ripple adder, one nibble per clock, LSB nibble first.
- Drives the adder operand/carry-in ports and captures its sum/carry.
- Sits between a requester (start/done handshake) and a shared 4-bit adder instance, so wide arithmetic needs no wide adder.

---
 rtl/nibble_serial_add_ctrl.sv | 147 ++++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial add/subtract sequencer.
// A WIDTH = 4*NIBBLES bit add or subtract is computed one nibble per clock,
// least significant nibble first, on a shared external 4-bit adder. The
// external adder is combinational. This block feeds its operand and carry
// ports from flops and captures its sum and carry on each edge.
module nibble_serial_add_ctrl #(
  parameter int unsigned NIBBLES = 4,
  localparam int unsigned WIDTH = 4 * NIBBLES
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic             cin_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic [3:0]       adder_r1_o,
  output logic [3:0]       adder_r2_o,
  output logic             adder_ci_o,
  input  logic [3:0]       adder_sum_i,
  input  logic             adder_carry_i
);

  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [IdxW-1:0] IdxLast = IdxW'(NIBBLES - 1);

  logic [1:0]       state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             carry_q, carry_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] eff_b;

  // Subtraction is A + ~B + 1. Inverting B once at accept time keeps the run loop mode-free.
  assign eff_b = sub_i ? ~op_b_i : op_b_i;

  // Next-state: accept in IDLE, one nibble per RUN cycle, single DONE cycle.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    carry_d  = carry_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          a_sh_d   = op_a_i;
          b_sh_d   = eff_b;
          carry_d  = sub_i ? 1'b1 : cin_i;
          a_msb_d  = op_a_i[WIDTH-1];
          b_msb_d  = eff_b[WIDTH-1];
          idx_d    = '0;
          result_d = '0;
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
          state_d  = StRun;
        end
      end

      StRun: begin
        result_d[{idx_q, 2'b00} +: 4] = adder_sum_i;
        // After NIBBLES shifts both operand registers are all-zero. This is what
        // parks the adder operand ports at 0 outside RUN without any output gating.
        a_sh_d  = a_sh_q >> 4;
        b_sh_d  = b_sh_q >> 4;
        carry_d = adder_carry_i;
        idx_d   = idx_q + IdxW'(1);
        if (idx_q == IdxLast) begin
          cout_d  = adder_carry_i;
          ovf_d   = (a_msb_q == b_msb_q) && (adder_sum_i[3] != a_msb_q);
          // Clear the running carry so adder_ci returns to 0. cout_q keeps the value.
          carry_d = 1'b0;
          idx_d   = '0;
          state_d = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers. Reset aborts any operation in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      carry_q  <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      carry_q  <= carry_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy_o   = (state_q == StRun) || (state_q == StDone);
  assign done_o   = (state_q == StDone);
  assign result_o = result_q;
  assign cout_o   = cout_q;
  assign ovf_o    = ovf_q;

  // Adder ports come straight from flops, so they are glitch-free.
  assign adder_r1_o = a_sh_q[3:0];
  assign adder_r2_o = b_sh_q[3:0];
  assign adder_ci_o = carry_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl. It drives a NIBBLES=4 and a NIBBLES=1
// instance, each against its own behavioural 4-bit adder. Expected results are
// queued when an operation is issued and compared when done pulses.
module tb_nibble_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- NIBBLES = 4 instance ----------------
  logic        start4, sub4, cin4;
  logic [15:0] a4, b4;
  logic        busy4, done4, cout4, ovf4;
  logic [15:0] result4;
  logic [3:0]  r1_4, r2_4, sum4;
  logic        ci4, carry4;

  assign {carry4, sum4} = {1'b0, r1_4} + {1'b0, r2_4} + {4'b0, ci4};

  nibble_serial_add_ctrl #(.NIBBLES(4)) u_dut4 (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start4),
    .sub_i        (sub4),
    .cin_i        (cin4),
    .op_a_i       (a4),
    .op_b_i       (b4),
    .busy_o       (busy4),
    .done_o       (done4),
    .result_o     (result4),
    .cout_o       (cout4),
    .ovf_o        (ovf4),
    .adder_r1_o   (r1_4),
    .adder_r2_o   (r2_4),
    .adder_ci_o   (ci4),
    .adder_sum_i  (sum4),
    .adder_carry_i(carry4)
  );

  // ---------------- NIBBLES = 1 instance ----------------
  logic        start1, sub1, cin1;
  logic [3:0]  a1, b1;
  logic        busy1, done1, cout1, ovf1;
  logic [3:0]  result1;
  logic [3:0]  r1_1, r2_1, sum1;
  logic        ci1, carry1;

  assign {carry1, sum1} = {1'b0, r1_1} + {1'b0, r2_1} + {4'b0, ci1};

  nibble_serial_add_ctrl #(.NIBBLES(1)) u_dut1 (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start1),
    .sub_i        (sub1),
    .cin_i        (cin1),
    .op_a_i       (a1),
    .op_b_i       (b1),
    .busy_o       (busy1),
    .done_o       (done1),
    .result_o     (result1),
    .cout_o       (cout1),
    .ovf_o        (ovf1),
    .adder_r1_o   (r1_1),
    .adder_r2_o   (r2_1),
    .adder_ci_o   (ci1),
    .adder_sum_i  (sum1),
    .adder_carry_i(carry1)
  );

  // Scoreboards: {ovf, cout, result}
  logic [17:0] q4[$];
  logic [5:0]  q1[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b,
                                          input logic s, input logic c);
    logic [15:0] bb;
    logic [16:0] t;
    logic        v;
    bb = s ? ~b : b;
    t  = {1'b0, a} + {1'b0, bb} + {16'b0, (s ? 1'b1 : c)};
    v  = (a[15] == bb[15]) && (t[15] != a[15]);
    return {v, t[16], t[15:0]};
  endfunction

  function automatic logic [5:0] model4(input logic [3:0] a, input logic [3:0] b,
                                        input logic s, input logic c);
    logic [3:0] bb;
    logic [4:0] t;
    logic       v;
    bb = s ? ~b : b;
    t  = {1'b0, a} + {1'b0, bb} + {4'b0, (s ? 1'b1 : c)};
    v  = (a[3] == bb[3]) && (t[3] != a[3]);
    return {v, t[4], t[3:0]};
  endfunction

  // Result monitors: every done pulse must match the oldest outstanding operation.
  logic [17:0] exp4;
  logic [5:0]  exp1;
  always @(negedge clk) begin
    if (done4) begin
      if (q4.size() == 0) begin
        check("done4_unexpected", 32'd1, 32'd0);
      end else begin
        exp4 = q4.pop_front();
        check("result4", {16'b0, result4}, {16'b0, exp4[15:0]});
        check("cout4", {31'b0, cout4}, {31'b0, exp4[16]});
        check("ovf4", {31'b0, ovf4}, {31'b0, exp4[17]});
      end
    end
    if (done1) begin
      if (q1.size() == 0) begin
        check("done1_unexpected", 32'd1, 32'd0);
      end else begin
        exp1 = q1.pop_front();
        check("result1", {28'b0, result1}, {28'b0, exp1[3:0]});
        check("cout1", {31'b0, cout1}, {31'b0, exp1[4]});
        check("ovf1", {31'b0, ovf1}, {31'b0, exp1[5]});
      end
    end
  end

  // One operation on the 4-nibble DUT. With poke set, start is re-pulsed mid-RUN and in DONE.
  task automatic run_op4(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic c, input bit poke);
    int          n;
    int          nb;
    logic [15:0] bb;
    bb = s ? ~b : b;
    @(negedge clk);
    start4 = 1'b1; a4 = a; b4 = b; sub4 = s; cin4 = c;
    q4.push_back(model16(a, b, s, c));
    @(posedge clk);
    #1;
    start4 = 1'b0;
    a4 = 16'($urandom); b4 = 16'($urandom); sub4 = ~s; cin4 = ~c;
    n = 0;
    nb = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy4) nb++;
      if (n == 1) begin
        check("adder_r1_first", {28'b0, r1_4}, {28'b0, a[3:0]});
        check("adder_r2_first", {28'b0, r2_4}, {28'b0, bb[3:0]});
        check("adder_ci_first", {31'b0, ci4}, {31'b0, (s ? 1'b1 : c)});
      end
      if (poke && n == 2) begin
        start4 = 1'b1; a4 = 16'h0F0F; b4 = 16'h1111; sub4 = 1'b0; cin4 = 1'b1;
      end
      if (poke && n == 3) start4 = 1'b0;
    end while (!done4 && n < 20);
    check("latency4", n, 5);
    check("busy_cycles4", nb, 5);
    if (poke) begin
      start4 = 1'b1;
      @(posedge clk);
      #1;
      start4 = 1'b0;
    end
    @(negedge clk);
    check("idle_busy4", {31'b0, busy4}, 32'd0);
    check("idle_ports4", {23'b0, r1_4, r2_4, ci4}, 32'd0);
  endtask

  task automatic run_op1(input logic [3:0] a, input logic [3:0] b, input logic s,
                         input logic c);
    int n;
    int nb;
    @(negedge clk);
    start1 = 1'b1; a1 = a; b1 = b; sub1 = s; cin1 = c;
    q1.push_back(model4(a, b, s, c));
    @(posedge clk);
    #1;
    start1 = 1'b0;
    a1 = 4'($urandom);
    b1 = 4'($urandom);
    n = 0;
    nb = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy1) nb++;
    end while (!done1 && n < 20);
    check("latency1", n, 2);
    check("busy_cycles1", nb, 2);
    @(negedge clk);
    check("idle_busy1", {31'b0, busy1}, 32'd0);
  endtask

  initial begin
    int cnt;
    int cyc;
    int last;
    rst = 1'b1;
    start4 = 1'b0; sub4 = 1'b0; cin4 = 1'b0; a4 = '0; b4 = '0;
    start1 = 1'b0; sub1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'b0, busy4}, 32'd0);
    check("rst_done", {31'b0, done4}, 32'd0);
    check("rst_result", {16'b0, result4}, 32'd0);
    check("rst_flags", {30'b0, cout4, ovf4}, 32'd0);
    check("rst_ports", {23'b0, r1_4, r2_4, ci4}, 32'd0);
    rst = 1'b0;

    run_op4(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    run_op4(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op4(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op4(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    run_op4(16'h0005, 16'h0007, 1'b1, 1'b0, 1'b0);
    run_op4(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0);
    run_op4(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0);
    run_op4(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0);
    run_op4(16'hA5C3, 16'h3C5A, 1'b0, 1'b1, 1'b1);
    check("held_result", {16'b0, result4}, {16'b0, model16(16'hA5C3, 16'h3C5A, 1'b0, 1'b1)
                                                    [15:0]});

    // start held high: three operations back-to-back, one every 6 cycles
    @(negedge clk);
    start4 = 1'b1; a4 = 16'h9ABC; b4 = 16'h1357; sub4 = 1'b1; cin4 = 1'b0;
    repeat (3) q4.push_back(model16(16'h9ABC, 16'h1357, 1'b1, 1'b0));
    cnt = 0; cyc = 0; last = 0;
    while (cnt < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done4) begin
        cnt++;
        if (cnt > 1) check("b2b_gap", cyc - last, 6);
        last = cyc;
        if (cnt == 3) start4 = 1'b0;
      end
    end
    check("b2b_count", cnt, 3);
    @(negedge clk);
    check("b2b_idle", {31'b0, busy4}, 32'd0);

    // asynchronous reset two cycles into RUN
    @(negedge clk);
    start4 = 1'b1; a4 = 16'h1234; b4 = 16'h4321; sub4 = 1'b0; cin4 = 1'b0;
    q4.push_back(model16(16'h1234, 16'h4321, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    start4 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("pre_rst_partial", {24'b0, result4[7:0]}, 32'h55);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'b0, busy4}, 32'd0);
    check("abort_done", {31'b0, done4}, 32'd0);
    check("abort_result", {16'b0, result4}, 32'd0);
    check("abort_ports", {23'b0, r1_4, r2_4, ci4}, 32'd0);
    q4.delete();
    #1;
    rst = 1'b0;
    repeat (8) @(negedge clk);
    run_op4(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);

    run_op1(4'hF, 4'h1, 1'b0, 1'b1);
    run_op1(4'h3, 4'h5, 1'b1, 1'b0);
    run_op1(4'h7, 4'h1, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    check("sb4_empty", q4.size(), 0);
    check("sb1_empty", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
